// File: rtl/gate_id_pkg.sv
// rtl/gate_id_pkg.sv - gate-type codes, expected truth tables and FSM states for gate_identifier
package gate_id_pkg;

  localparam logic [2:0] GT_AND     = 3'd0;
  localparam logic [2:0] GT_OR      = 3'd1;
  localparam logic [2:0] GT_NOT_A   = 3'd2;
  localparam logic [2:0] GT_NAND    = 3'd3;
  localparam logic [2:0] GT_NOR     = 3'd4;
  localparam logic [2:0] GT_XOR     = 3'd5;
  localparam logic [2:0] GT_XNOR    = 3'd6;
  localparam logic [2:0] GT_UNKNOWN = 3'd7;

  // Tables are indexed by {A,B}: bit 3 is A=1,B=1, bit 0 is A=0,B=0.
  localparam logic [3:0] TT_AND   = 4'b1000;
  localparam logic [3:0] TT_OR    = 4'b1110;
  localparam logic [3:0] TT_NOT_A = 4'b0011;
  localparam logic [3:0] TT_NAND  = 4'b0111;
  localparam logic [3:0] TT_NOR   = 4'b0001;
  localparam logic [3:0] TT_XOR   = 4'b0110;
  localparam logic [3:0] TT_XNOR  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/gate_id_decode.sv
// rtl/gate_id_decode.sv - combinational truth-table to gate-type decoder
module gate_id_decode
  import gate_id_pkg::*;
(
  input  logic [3:0] truth,
  output logic       valid,
  output logic [2:0] gate_type
);

  always_comb begin
    valid     = 1'b1;
    gate_type = GT_UNKNOWN;
    case (truth)
      TT_AND:   gate_type = GT_AND;
      TT_OR:    gate_type = GT_OR;
      TT_NOT_A: gate_type = GT_NOT_A;
      TT_NAND:  gate_type = GT_NAND;
      TT_NOR:   gate_type = GT_NOR;
      TT_XOR:   gate_type = GT_XOR;
      TT_XNOR:  gate_type = GT_XNOR;
      default:  valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_identifier.sv
// rtl/gate_identifier.sv - sweeps a 2-input gate through all vectors and decodes its function
// Optional GATE_ID_DOUBLE_SWEEP_EN: two sweeps per start, second table checked against the first.
module gate_identifier
  import gate_id_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       probe_a,
  output logic       probe_b,
  input  logic       probe_o,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] gate_type,
  output logic       valid,
  output logic       mismatch
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  state_t          state, state_next;
  logic [1:0]      idx;
  logic [CW-1:0]   cnt;
  logic [3:0]      table_q, table_next;
  logic            sample, final_pass;
  logic            dec_valid;
  logic [2:0]      dec_type;

`ifdef GATE_ID_DOUBLE_SWEEP_EN
  logic       pass_q;
  logic       mismatch_q;
  logic [3:0] first_q;
  assign final_pass = pass_q;
  assign mismatch   = mismatch_q;
`else
  assign final_pass = 1'b1;
  assign mismatch   = 1'b0;
`endif

  assign sample = (state == ST_SETTLE) && (cnt == CNT_LAST);

  // Decoding the table including the bit being captured lets results land as DONE begins.
  always_comb begin
    table_next = table_q;
    if (sample) table_next[idx] = probe_o;
  end

  gate_id_decode u_decode (
    .truth     (table_next),
    .valid     (dec_valid),
    .gate_type (dec_type)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_SETTLE;
      ST_SETTLE: if (sample && (idx == 2'd3) && final_pass) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign probe_a = (state == ST_SETTLE) ? idx[1] : 1'b0;
  assign probe_b = (state == ST_SETTLE) ? idx[0] : 1'b0;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      table_q   <= 4'b0000;
      truth     <= 4'b0000;
      gate_type <= GT_UNKNOWN;
      valid     <= 1'b0;
`ifdef GATE_ID_DOUBLE_SWEEP_EN
      pass_q     <= 1'b0;
      mismatch_q <= 1'b0;
      first_q    <= 4'b0000;
`endif
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx <= 2'd0;
            cnt <= '0;
`ifdef GATE_ID_DOUBLE_SWEEP_EN
            pass_q     <= 1'b0;
            mismatch_q <= 1'b0;
`endif
          end
        end
        ST_SETTLE: begin
          if (sample) begin
            table_q <= table_next;
            cnt     <= '0;
            idx     <= idx + 2'd1;
            if (idx == 2'd3) begin
`ifdef GATE_ID_DOUBLE_SWEEP_EN
              if (!pass_q) begin
                first_q <= table_next;
                pass_q  <= 1'b1;
              end else begin
                truth <= table_next;
                if (table_next != first_q) begin
                  mismatch_q <= 1'b1;
                  gate_type  <= GT_UNKNOWN;
                  valid      <= 1'b0;
                end else begin
                  gate_type <= dec_type;
                  valid     <= dec_valid;
                end
              end
`else
              truth     <= table_next;
              gate_type <= dec_type;
              valid     <= dec_valid;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gate_identifier.md
# gate_identifier

Sequential characterizer for a 2-input, 7-function configurable gate. It drives the gate's A/B inputs through all four input combinations, samples the gate output after a settle delay, and decodes the captured truth table back into the 3-bit gate-type code. It sits on the test/bring-up side of the gate array and reports which function a gate instance implements.

## Interface
- SETTLE_CYCLES, default 2: cycles each stimulus vector is held before sampling; legal range ≥ 1.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; honored only in IDLE.
- probe_a  out  1  stimulus to gate input A.
- probe_b  out  1  stimulus to gate input B.
- probe_o  in  1  gate output under test.
- busy  out  1  high while a sweep or result cycle is in progress.
- done  out  1  single-cycle pulse; results valid from this cycle.
- truth  out  4  captured table; truth[{A,B}] = probe_o for that vector.
- gate_type  out  3  decoded code: 0 AND, 1 OR, 2 NOT(A), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 unknown.
- valid  out  1  truth matched a known function.
- mismatch  out  1  repeat sweep disagreed; see Configuration.

## Operation
- States: IDLE, SETTLE, DONE.
- IDLE: probes 00. start=1 moves to SETTLE with idx=0 and cnt=0, clears mismatch.
- SETTLE: {probe_a,probe_b}=idx. cnt counts 0..SETTLE_CYCLES-1. At cnt=SETTLE_CYCLES-1, capture probe_o into truth[idx]. If idx=3, go to DONE; otherwise increment idx and clear cnt.
- DONE: decode truth, register gate_type and valid, pulse done, then return to IDLE. Probes are 00 in DONE.
- Decode table (truth[3:0]): 1000→0, 1110→1, 0011→2, 0111→3, 0001→4, 0110→5, 1001→6. Any other pattern → gate_type=7, valid=0.
- truth, gate_type and valid hold until the next DONE. A new sweep does not clear them early.
- start is ignored in SETTLE and DONE.
- busy = (state != IDLE).

## Timing
- Reset values: probe_a=0, probe_b=0, busy=0, done=0, truth=0000, gate_type=7, valid=0, mismatch=0. State returns to IDLE.
- Latency: start sampled in cycle 0. Vector idx is driven during cycles 1+idx·SETTLE_CYCLES through (idx+1)·SETTLE_CYCLES. done is high in cycle 4·SETTLE_CYCLES+1, which is cycle 9 at the default.
- With start held high continuously, sweeps run back-to-back. done recurs every 4·SETTLE_CYCLES+2 cycles.
- Reset mid-sweep: aborts the sweep. Next cycle is IDLE with probes 00, no done pulse, and all results at reset values.
- The gate output must be stable within SETTLE_CYCLES-1 cycles of a probe change. The sample is taken on the last held cycle.

## Configuration
- GATE_ID_DOUBLE_SWEEP_EN defined: each start performs two full sweeps.
  - The first table is kept; the second table is compared bit-for-bit.
  - On mismatch: mismatch=1, valid=0, gate_type=7, and truth reports the second table.
  - done is in cycle 8·SETTLE_CYCLES+1.
- Undefined: single sweep as above. mismatch is tied to 0.

## Structure
- Package gate_id_pkg holds:
  - gate-type code localparams 0–7;
  - the seven expected truth-table constants;
  - the state enum.
- Sub-module gate_id_decode: purely combinational, 4-bit truth in, {valid, gate_type} out. It is instantiated once, with its output registered in DONE.

## Test plan
- Behavioral AND model, SETTLE_CYCLES=2, start pulse in cycle 0 → probes 00,01,10,11 for two cycles each; done in cycle 9; truth=1000, gate_type=0, valid=1.
- Models for codes 0–6 in sequence → gate_type matches the model code each time; NOT model gives truth=0011.
- Model with output stuck at 0 → truth=0000, gate_type=7, valid=0.
- rst asserted in cycle 4 of a sweep → busy=0 and probes 00 in cycle 5; no done; gate_type=7.
- start held high in IDLE, with extra start pulses while busy → done every 10 cycles; mid-sweep pulses do not restart.
- With GATE_ID_DOUBLE_SWEEP_EN: model flips from AND to OR between sweeps → done in cycle 17, mismatch=1, valid=0, gate_type=7, truth=1110.
